frequency_analyzer_axi_reader: RTL and testbench

FREQUENCY_ANALYZER_AXI_READER -- requirements
Module: frequency_analyzer_axi_reader

---
 rtl/frequency_analyzer_pkg.sv | 29 ++
 rtl/frequency_analyzer_axi_reader.sv | 238 +++++++++++++++++++++++
 tb/tb_frequency_analyzer_axi_reader.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frequency_analyzer_pkg.sv
// -----------------------------------------------------------------------------
// frequency_analyzer_pkg
//   Shared definitions for the frequency analyzer AXI4-Lite reader. It holds
//   the FSM state encoding, the AXI response codes, and a small helper that
//   classifies a response as a fault.
// -----------------------------------------------------------------------------
package frequency_analyzer_pkg;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // The manager only issues plain accesses, so any response other than OKAY
  // counts as a fault.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/frequency_analyzer_axi_reader.sv
// -----------------------------------------------------------------------------
// frequency_analyzer_axi_reader
//   An AXI4-Lite master. It waits for a rising edge on the analyzer's
//   completion interrupt. It then reads REG_COUNT result registers, starting
//   at BASE_ADDR, one transaction at a time. Each returned word is presented
//   on a one-cycle result strobe. After the last read, the block writes
//   CLEAR_VALUE to CLEAR_ADDR to re-arm the analyzer, and it ends the
//   sequence with a one-cycle done pulse.
//
//   The error flag is sticky until the next trigger. It is set by any
//   non-OKAY response and by a watchdog: the watchdog fires when no state
//   change occurs within TIMEOUT_CYCLES. On a timeout the block drops every
//   valid/ready and goes straight to DONE.
//
// Ports
//   m00_axi_aclk / m00_axi_aresetn  clock, asynchronous active-low reset
//   irq                             level interrupt; only its rising edge triggers
//   busy                            high whenever a sequence is in progress
//   result_valid/_index/_data       one-cycle strobe with register ordinal and data
//   done                            one-cycle end-of-sequence pulse
//   error                           sticky fault flag
//   m00_axi_ar*/r*                  read address and read data channels
//   m00_axi_aw*/w*/b*               write address, write data and write response channels
// -----------------------------------------------------------------------------
module frequency_analyzer_axi_reader
  import frequency_analyzer_pkg::*;
#(
  parameter int                                C_M00_AXI_DATA_WIDTH = 32,
  parameter int                                C_M00_AXI_ADDR_WIDTH = 10,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0]   BASE_ADDR            = '0,
  parameter int                                REG_COUNT            = 6,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0]   CLEAR_ADDR           = 'h18,
  parameter logic [C_M00_AXI_DATA_WIDTH-1:0]   CLEAR_VALUE          = 'd1,
  parameter int                                TIMEOUT_CYCLES       = 1024
) (
  input  logic                                m00_axi_aclk,
  input  logic                                m00_axi_aresetn,

  input  logic                                irq,
  output logic                                busy,
  output logic                                result_valid,
  output logic [2:0]                          result_index,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     result_data,
  output logic                                done,
  output logic                                error,

  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                          m00_axi_arprot,
  output logic                                m00_axi_arvalid,
  input  logic                                m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                          m00_axi_rresp,
  input  logic                                m00_axi_rvalid,
  output logic                                m00_axi_rready,

  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                          m00_axi_awprot,
  output logic                                m00_axi_awvalid,
  input  logic                                m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                                m00_axi_wvalid,
  input  logic                                m00_axi_wready,
  input  logic [1:0]                          m00_axi_bresp,
  input  logic                                m00_axi_bvalid,
  output logic                                m00_axi_bready
);

  localparam int         TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST_IDX = 3'(REG_COUNT - 1);

  logic [2:0]                      state_q,     state_d;
  logic                            irq_q;
  logic [2:0]                      index_q,     index_d;
  logic                            error_q,     error_d;
  logic                            aw_pend_q,   aw_pend_d;
  logic                            w_pend_q,    w_pend_d;
  logic [TMR_W-1:0]                timer_q,     timer_d;
  logic                            res_valid_q, res_valid_d;
  logic [2:0]                      res_index_q, res_index_d;
  logic [C_M00_AXI_DATA_WIDTH-1:0] res_data_q,  res_data_d;

  logic irq_rise;
  logic timeout_hit;

  assign irq_rise    = irq && !irq_q;
  assign timeout_hit = (timer_q == TMR_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // it unassigned and infer a latch.
    state_d     = state_q;
    index_d     = index_q;
    error_d     = error_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    res_valid_d = 1'b0;
    res_index_d = res_index_q;
    res_data_d  = res_data_q;

    case (state_q)
      ST_IDLE: begin
        if (irq_rise) begin
          state_d = ST_RD_ADDR;
          index_d = '0;
          error_d = 1'b0;
        end
      end

      ST_RD_ADDR: begin
        if (m00_axi_arready) begin
          state_d = ST_RD_DATA;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_RD_DATA: begin
        if (m00_axi_rvalid) begin
          res_valid_d = 1'b1;
          res_index_d = index_q;
          res_data_d  = m00_axi_rdata;
          if (resp_is_error(m00_axi_rresp)) error_d = 1'b1;
          if (index_q < LAST_IDX) begin
            index_d = index_q + 3'd1;
            state_d = ST_RD_ADDR;
          end else begin
            // Both write channels are launched together. Each then retires
            // on its own handshake.
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = ST_WR;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_WR: begin
        aw_pend_d = aw_pend_q && !m00_axi_awready;
        w_pend_d  = w_pend_q  && !m00_axi_wready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = ST_WR_RESP;
        end else if (timeout_hit) begin
          aw_pend_d = 1'b0;
          w_pend_d  = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_WR_RESP: begin
        if (m00_axi_bvalid) begin
          if (resp_is_error(m00_axi_bresp)) error_d = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // The watchdog measures time spent in the current state. It is not
    // running while idle.
    if (state_d != state_q || state_q == ST_IDLE) timer_d = '0;
    else                                          timer_d = timer_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q     <= ST_IDLE;
      irq_q       <= 1'b0;
      index_q     <= '0;
      error_q     <= 1'b0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq;
      index_q     <= index_d;
      error_q     <= error_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_index_q <= res_index_d;
      res_data_q  <= res_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // These are decoded from registered state, so they fall to zero as soon as
  // reset is asserted. Address and data are zeroed whenever the matching
  // valid is low.
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign error        = error_q;
  assign result_valid = res_valid_q;
  assign result_index = res_index_q;
  assign result_data  = res_data_q;

  assign m00_axi_arvalid = (state_q == ST_RD_ADDR);
  assign m00_axi_araddr  = m00_axi_arvalid
                         ? BASE_ADDR + (C_M00_AXI_ADDR_WIDTH'(index_q) << 2)
                         : '0;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_rready  = (state_q == ST_RD_DATA);

  assign m00_axi_awvalid = aw_pend_q;
  assign m00_axi_awaddr  = aw_pend_q ? CLEAR_ADDR : '0;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_wvalid  = w_pend_q;
  assign m00_axi_wdata   = w_pend_q ? CLEAR_VALUE : '0;
  assign m00_axi_wstrb   = w_pend_q ? '1 : '0;
  assign m00_axi_bready  = (state_q == ST_WR_RESP);

endmodule

// File: tb/tb_frequency_analyzer_axi_reader.sv
// -----------------------------------------------------------------------------
// tb_frequency_analyzer_axi_reader
//   This bench provides a behavioural AXI4-Lite slave with configurable
//   per-channel wait states and a per-register data/response table. A
//   negedge monitor logs the result strobes and the done pulse. Each scenario
//   compares the logged traffic against a reference sequence built directly
//   from the reader's contract:
//     - REG_COUNT reads at BASE + 4*i,
//     - strobes (i, data[i]),
//     - one clear write,
//     - error as the OR of all faulty responses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frequency_analyzer_axi_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NREG = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          irq = 1'b0;
  logic          busy, result_valid, done, error;
  logic [2:0]    result_index;
  logic [DW-1:0] result_data;
  logic [AW-1:0] araddr, awaddr;
  logic [2:0]    arprot, awprot;
  logic          arvalid, rready, awvalid, wvalid, bready;
  logic          arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [DW-1:0] rdata = '0, wdata;
  logic [3:0]    wstrb;
  logic [1:0]    rresp = 2'b00, bresp = 2'b00;

  always #5 clk = ~clk;

  frequency_analyzer_axi_reader dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .irq(irq), .busy(busy), .result_valid(result_valid),
    .result_index(result_index), .result_data(result_data),
    .done(done), .error(error),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Slave configuration
  int            cfg_ar_delay, cfg_r_delay, cfg_aw_delay, cfg_w_delay, cfg_b_delay;
  bit            cfg_ar_never;
  logic [7:0]    cfg_err_mask;
  logic [1:0]    cfg_bresp;
  logic [DW-1:0] rd_data [8];

  // Slave / monitor logs
  logic [AW-1:0] ar_log[$];
  logic [2:0]    res_idx_log[$];
  logic [DW-1:0] res_data_log[$];
  int            aw_count, w_count, b_count, done_count, ar_high_cycles;
  int            viol_overlap, viol_ar_r, viol_addr, viol_w_after, viol_aw_after, viol_prot;
  int            cyc, w_hs_cyc, aw_hs_cyc;
  logic [AW-1:0] aw_addr_seen;
  logic [DW-1:0] w_data_seen;
  logic [3:0]    w_strb_seen;
  logic          done_arvalid, done_err;

  // ---------------------------------------------------------------------------
  // Behavioural slave. Inputs change only at negedge, so a handshake happens
  // at the following posedge exactly when valid && ready holds here.
  // ---------------------------------------------------------------------------
  initial begin : slave
    int ar_wait, r_wait, aw_wait, w_wait, b_wait, idx;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, aw_done, w_done, prev_arvalid;
    logic [AW-1:0] hs_araddr, hs_awaddr, prev_araddr, r_addr;
    logic [DW-1:0] hs_wdata;
    logic [3:0]    hs_wstrb;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        r_pend = 0; aw_done = 0; w_done = 0; prev_arvalid = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        continue;
      end
      if (r_hs) r_pend = 0;
      if (ar_hs) begin
        if (r_pend) viol_overlap++;
        ar_log.push_back(hs_araddr);
        r_pend = 1; r_addr = hs_araddr; r_wait = 0;
      end
      if (w_hs) begin
        w_count++; w_data_seen = hs_wdata; w_strb_seen = hs_wstrb; w_done = 1; w_hs_cyc = cyc;
      end
      if (aw_hs) begin
        aw_count++; aw_addr_seen = hs_awaddr; aw_done = 1; aw_hs_cyc = cyc;
      end
      if (b_hs) begin
        b_count++; aw_done = 0; w_done = 0; b_wait = 0;
      end

      if (arvalid && rready) viol_ar_r++;
      if (prev_arvalid && !ar_hs && arvalid && araddr != prev_araddr) viol_addr++;
      if (w_done && wvalid) viol_w_after++;
      if (aw_done && awvalid) viol_aw_after++;
      if (arprot != 3'b000 || awprot != 3'b000) viol_prot++;
      if (arvalid) ar_high_cycles++;

      arready = 0;
      if (arvalid && !cfg_ar_never) begin
        if (ar_wait >= cfg_ar_delay) begin arready = 1; ar_wait = 0; end
        else ar_wait++;
      end
      rvalid = 0;
      if (r_pend) begin
        if (r_wait >= cfg_r_delay) begin
          idx = int'(r_addr) / 4;
          rvalid = 1;
          rdata  = rd_data[idx[2:0]];
          rresp  = cfg_err_mask[idx[2:0]] ? 2'b10 : 2'b00;
        end else r_wait++;
      end
      awready = 0;
      if (awvalid) begin
        if (aw_wait >= cfg_aw_delay) begin awready = 1; aw_wait = 0; end
        else aw_wait++;
      end
      wready = 0;
      if (wvalid) begin
        if (w_wait >= cfg_w_delay) begin wready = 1; w_wait = 0; end
        else w_wait++;
      end
      bvalid = 0;
      if (aw_done && w_done) begin
        if (b_wait >= cfg_b_delay) begin bvalid = 1; bresp = cfg_bresp; end
        else b_wait++;
      end

      ar_hs = arvalid && arready; hs_araddr = araddr;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready; hs_awaddr = awaddr;
      w_hs  = wvalid && wready;   hs_wdata = wdata; hs_wstrb = wstrb;
      b_hs  = bvalid && bready;
      prev_arvalid = arvalid; prev_araddr = araddr;
    end
  end

  // Output monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (result_valid) begin
          res_idx_log.push_back(result_index);
          res_data_log.push_back(result_data);
        end
        if (done) begin
          done_count++; done_arvalid = arvalid; done_err = error;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus only)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic set_slave(input int ard, input int rd, input int awd, input int wd,
                           input int bd, input logic [7:0] emask, input logic [1:0] br);
    cfg_ar_delay = ard; cfg_r_delay = rd; cfg_aw_delay = awd; cfg_w_delay = wd;
    cfg_b_delay = bd; cfg_err_mask = emask; cfg_bresp = br; cfg_ar_never = 0;
  endtask

  task automatic clear_logs();
    ar_log.delete(); res_idx_log.delete(); res_data_log.delete();
    aw_count = 0; w_count = 0; b_count = 0; done_count = 0; ar_high_cycles = 0;
    viol_overlap = 0; viol_ar_r = 0; viol_addr = 0; viol_w_after = 0;
    viol_aw_after = 0; viol_prot = 0; w_hs_cyc = 0; aw_hs_cyc = 0;
    done_arvalid = 0; done_err = 0;
  endtask

  // Raises irq with a clean edge and leaves it high.
  task automatic fire_irq();
    clear_logs();
    irq = 0; tick();
    irq = 1; tick();
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done_count == 0 && n < limit) begin tick(); n++; end
    cmp_cnt++;
    if (done_count == 0) begin
      err_cnt++;
      $display("FAIL %s: no done pulse within %0d cycles", tag, limit);
    end
  endtask

  // Scoreboard: checks the logged traffic against the reference sequence
  // that the slave configuration implies.
  task automatic score_run(input string tag);
    logic exp_err;
    exp_err = (cfg_err_mask[NREG-1:0] != '0) || (cfg_bresp != 2'b00);
    cmp_cnt++;
    if (ar_log.size() != NREG) begin
      err_cnt++; $display("FAIL %s ar_count: got %0d want %0d", tag, ar_log.size(), NREG);
    end
    for (int i = 0; i < NREG && i < ar_log.size(); i++) begin
      cmp_cnt++;
      if (ar_log[i] !== AW'(4 * i)) begin
        err_cnt++; $display("FAIL %s araddr[%0d]: got %h want %h", tag, i, ar_log[i], AW'(4 * i));
      end
    end
    cmp_cnt++;
    if (res_idx_log.size() != NREG) begin
      err_cnt++; $display("FAIL %s result_count: got %0d want %0d", tag, res_idx_log.size(), NREG);
    end
    for (int i = 0; i < NREG && i < res_idx_log.size(); i++) begin
      cmp_cnt++;
      if (res_idx_log[i] !== 3'(i) || res_data_log[i] !== rd_data[i]) begin
        err_cnt++;
        $display("FAIL %s result[%0d]: got idx %0d data %h want idx %0d data %h",
                 tag, i, res_idx_log[i], res_data_log[i], i, rd_data[i]);
      end
    end
    cmp_cnt++;
    if (aw_count != 1 || w_count != 1 || b_count != 1) begin
      err_cnt++; $display("FAIL %s write_counts: got aw %0d w %0d b %0d want 1/1/1",
                          tag, aw_count, w_count, b_count);
    end
    cmp_cnt++;
    if (aw_addr_seen !== AW'('h18) || w_data_seen !== DW'(1) || w_strb_seen !== 4'hf) begin
      err_cnt++; $display("FAIL %s clear_write: got addr %h data %h strb %h want 018 1 f",
                          tag, aw_addr_seen, w_data_seen, w_strb_seen);
    end
    cmp_cnt++;
    if (done_count != 1 || done_err !== exp_err || error !== exp_err) begin
      err_cnt++; $display("FAIL %s done/error: got done %0d err@done %b err %b want 1 %b",
                          tag, done_count, done_err, error, exp_err);
    end
    cmp_cnt++;
    if (viol_overlap + viol_ar_r + viol_addr + viol_w_after + viol_aw_after + viol_prot != 0) begin
      err_cnt++; $display("FAIL %s protocol: overlap %0d ar_r %0d addr %0d w %0d aw %0d prot %0d want 0",
                          tag, viol_overlap, viol_ar_r, viol_addr, viol_w_after, viol_aw_after, viol_prot);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) rd_data[i] = DW'('h100 + i);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 0; irq = 0;
    set_slave(0, 0, 0, 0, 0, 8'h00, 2'b00);
    repeat (3) tick();
    cmp_cnt++;
    if ({busy, done, error, result_valid, arvalid, rready, awvalid, wvalid, bready} !== 9'b0 ||
        result_index !== 3'd0 || result_data !== '0 || araddr !== '0 || awaddr !== '0 || wdata !== '0) begin
      err_cnt++; $display("FAIL reset_state: outputs not all zero (busy %b done %b err %b arv %b)",
                          busy, done, error, arvalid);
    end
    rst_n = 1; tick();
  endtask

  task automatic test_zero_wait();
    load_ramp();
    set_slave(0, 0, 0, 0, 0, 8'h00, 2'b00);
    fire_irq();
    wait_done("zero_wait", 200);
    score_run("zero_wait");
    // irq is still high. A level without a new edge must not start another sequence.
    begin
      bit saw_busy = 0;
      repeat (12) begin tick(); if (busy) saw_busy = 1; end
      cmp_cnt++;
      if (saw_busy || ar_log.size() != NREG) begin
        err_cnt++; $display("FAIL level_no_retrigger: got busy %b reads %0d want 0 %0d",
                            saw_busy, ar_log.size(), NREG);
      end
    end
    irq = 0; tick();
  endtask

  task automatic test_delayed_read();
    load_ramp();
    set_slave(3, 5, 0, 0, 0, 8'h00, 2'b00);
    fire_irq(); irq = 0;
    wait_done("delayed_read", 500);
    score_run("delayed_read");
  endtask

  task automatic test_rresp_error();
    load_ramp();
    set_slave(0, 1, 0, 0, 0, 8'h08, 2'b00);
    fire_irq(); irq = 0;
    wait_done("rresp_error", 300);
    score_run("rresp_error");
  endtask

  task automatic test_write_order();
    load_ramp();
    set_slave(0, 0, 2, 0, 1, 8'h00, 2'b00);
    fire_irq(); irq = 0;
    wait_done("write_order", 300);
    score_run("write_order");
    cmp_cnt++;
    if (aw_hs_cyc - w_hs_cyc != 2) begin
      err_cnt++; $display("FAIL write_order_gap: got aw-w %0d cycles want 2", aw_hs_cyc - w_hs_cyc);
    end
  endtask

  task automatic test_timeout();
    load_ramp();
    set_slave(0, 0, 0, 0, 0, 8'h00, 2'b00);
    cfg_ar_never = 1;
    fire_irq(); irq = 0;
    wait_done("timeout", 1200);
    cmp_cnt++;
    if (done_err !== 1'b1 || done_arvalid !== 1'b0 || ar_high_cycles != 1024) begin
      err_cnt++; $display("FAIL timeout: got err %b arvalid %b ar_cycles %0d want 1 0 1024",
                          done_err, done_arvalid, ar_high_cycles);
    end
    tick();
    cmp_cnt++;
    if (busy !== 1'b0 || error !== 1'b1 || ar_log.size() != 0 || aw_count != 0) begin
      err_cnt++; $display("FAIL timeout_after: got busy %b err %b reads %0d aw %0d want 0 1 0 0",
                          busy, error, ar_log.size(), aw_count);
    end
    cfg_ar_never = 0;
  endtask

  task automatic test_busy_edge();
    load_ramp();
    set_slave(2, 2, 0, 0, 0, 8'h00, 2'b00);
    fire_irq();
    irq = 0; repeat (4) tick();
    irq = 1; tick();               // edge while busy: to be ignored
    irq = 0;
    wait_done("busy_edge", 400);
    score_run("busy_edge");
    begin
      bit saw_busy = 0;
      repeat (10) begin tick(); if (busy) saw_busy = 1; end
      cmp_cnt++;
      if (saw_busy || done_count != 1) begin
        err_cnt++; $display("FAIL busy_edge_queued: got busy %b done %0d want 0 1", saw_busy, done_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    load_ramp();
    set_slave(0, 30, 0, 0, 0, 8'h00, 2'b00);
    fire_irq(); irq = 0;
    while (!rready && n < 50) begin tick(); n++; end
    cmp_cnt++;
    if (!rready) begin
      err_cnt++; $display("FAIL reset_mid_reach: rready %b want 1", rready);
    end
    #2 rst_n = 0; #1;
    cmp_cnt++;
    if ({busy, done, error, result_valid, arvalid, rready, awvalid, wvalid, bready} !== 9'b0 ||
        result_index !== 3'd0 || result_data !== '0 || araddr !== '0) begin
      err_cnt++; $display("FAIL reset_mid_outputs: got busy %b rready %b idx %0d data %h want zeros",
                          busy, rready, result_index, result_data);
    end
    repeat (3) tick();
    rst_n = 1; tick();
    set_slave(0, 0, 0, 0, 0, 8'h00, 2'b00);
    fire_irq(); irq = 0;
    wait_done("after_reset", 200);
    score_run("after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) rd_data[i] = $urandom;
      set_slave($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00);
      fire_irq(); irq = 0;
      wait_done($sformatf("random%0d", it), 600);
      score_run($sformatf("random%0d", it));
      repeat ($urandom_range(1, 4)) tick();
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_zero_wait();
    test_delayed_read();
    test_rresp_error();
    test_write_order();
    test_timeout();
    test_busy_edge();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
